uart_rx_os: RTL

Parametrised, oversampling UART receiver that replaces the fixed 8N1 receiver in the serial command path (host PC → game control). It synchronises the asynchronous `rx` pin, samples each bit at 16× baud with 3-sample majority voting, and supports configurable data width, parity and stop bits. It reports parity, framing and overrun errors, and buffers received characters in a small first-word-fall-through FIFO with a valid/ready output handshake.

---
 rtl/uart_rx_os.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 16x tick, 3-sample majority vote, configurable
// framing, error flags and a small first-word-fall-through output FIFO.
module uart_rx_os #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_perr,
  output logic                 m_ferr,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun,
  output logic                 busy
);

  localparam int OS_DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int TCW    = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam int IW     = $clog2(DATA_BITS);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int EW     = DATA_BITS + 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [TCW-1:0]       tcnt_q;
  logic                 tick;
  logic [3:0]           sc_q;
  logic [IW-1:0]        idx_q;
  logic                 stop_q;
  logic [1:0]           smp_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 perr_q, ferr_q;
  logic                 vote, at_mid, at_end, last_data, last_stop;
  logic                 perr_n, ferr_n, push;
  logic [EW-1:0]        push_ent;

  // Two-flop synchroniser, reset to the idle line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

  assign tick = (tcnt_q == TCW'(OS_DIV - 1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tcnt_q <= '0;
    else if (tick) tcnt_q <= '0;
    else           tcnt_q <= tcnt_q + TCW'(1);
  end

  // Samples at sc=7 and 8 are held; the third comes live at sc=9.
  assign vote      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign at_mid    = tick && (sc_q == 4'd9);
  assign at_end    = tick && (sc_q == 4'd15);
  assign last_data = (idx_q == IW'(DATA_BITS - 1));
  assign last_stop = (STOP_BITS == 1) || stop_q;
  assign ferr_n    = ferr_q | ~vote;

  always_comb begin
    perr_n = 1'b0;
    if (PARITY == 1)      perr_n = ^{data_q, vote};
    else if (PARITY == 2) perr_n = ~(^{data_q, vote});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (tick && !rx_s) state_d = S_START;
      S_START:  if (at_mid && vote) state_d = S_IDLE;
                else if (at_end)    state_d = S_DATA;
      S_DATA:   if (at_end && last_data) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (at_end) state_d = S_STOP;
      S_STOP:   if (at_mid && last_stop) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Frame completes mid final stop bit so the next start edge is caught early.
  always_comb begin
    busy     = (state_q != S_IDLE);
    push     = (state_q == S_STOP) && at_mid && last_stop;
    push_ent = {ferr_n, perr_q, data_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sc_q   <= '0;
      idx_q  <= '0;
      stop_q <= 1'b0;
      smp_q  <= 2'b11;
      data_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      sc_q   <= '0;
      idx_q  <= '0;
      stop_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else if (tick) begin
      sc_q <= sc_q + 4'd1;
      if (sc_q == 4'd7) smp_q[0] <= rx_s;
      if (sc_q == 4'd8) smp_q[1] <= rx_s;
      if (sc_q == 4'd9) begin
        case (state_q)
          S_DATA:   data_q[idx_q] <= vote;
          S_PARITY: perr_q <= perr_n;
          S_STOP:   ferr_q <= ferr_n;
          default: ;
        endcase
      end
      if (sc_q == 4'd15) begin
        if (state_q == S_DATA && !last_data) idx_q <= idx_q + IW'(1);
        if (state_q == S_STOP) stop_q <= 1'b1;
      end
    end
  end

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wp_q, rp_q;
  logic          empty, full, pop, wr_en;

  assign empty   = (wp_q == rp_q);
  assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign m_valid = ~empty;
  assign pop     = m_valid & m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en   = push & (~full | pop);
  assign overrun = push & full & ~pop;
  assign {m_ferr, m_perr, m_data} = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wp_q[AW-1:0]] <= push_ent;
        wp_q <= wp_q + (AW+1)'(1);
      end
      if (pop) rp_q <= rp_q + (AW+1)'(1);
    end
  end

endmodule
